// File: rtl/as_dmem_arbiter_pkg.sv
// Shared widths and types for the data-memory arbiter.
package as_pack;

    localparam int reg_width       = 64;
    localparam int dmem_addr_width = 16;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } arb_state_t;

    // addr holds the doubleword index; byte offset bits never reach the RAM.
    typedef struct packed {
        logic                         we;
        logic [dmem_addr_width-4:0]   addr;
        logic [reg_width-1:0]         wdata;
        logic [7:0]                   byteEn;
    } dmem_cmd_t;

endpackage

// File: rtl/as_dmem_arbiter_rr_pick.sv
// Two-way round-robin selector; a held lock keeps the current owner while it still requests.
module as_rr_pick (
    input  logic [1:0] i_req,
    input  logic       i_last,
    input  logic       i_lock,
    input  logic       i_own,
    output logic       o_winner
);

    always_comb begin
        if (i_lock && i_req[i_own]) begin
            o_winner = i_own;
        end else if (i_req == 2'b01) begin
            o_winner = 1'b0;
        end else if (i_req == 2'b10) begin
            o_winner = 1'b1;
        end else begin
            o_winner = ~i_last;
        end
    end

endmodule

// File: rtl/as_dmem_arbiter.sv
// Arbitrates the single data-memory port between core (0) and loader (1).
// All outputs are registered; rdata_o is gated by the registered rvalid.
module as_dmem_arbiter
    import as_pack::*;
#(
    parameter int NREQ      = 2,
    parameter int MAX_BURST = 4
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [NREQ-1:0]                       req_i,
    input  logic [NREQ-1:0]                       lock_i,
    input  logic [NREQ-1:0]                       we_i,
    input  logic [NREQ-1:0][dmem_addr_width-1:0]  addr_i,
    input  logic [NREQ-1:0][reg_width-1:0]        wdata_i,
    input  logic [NREQ-1:0][7:0]                  byteEn_i,
    output logic [NREQ-1:0]                       gnt_o,
    output logic [NREQ-1:0]                       rvalid_o,
    output logic [reg_width-1:0]                  rdata_o,
    output logic                                  mem_en_o,
    output logic                                  mem_we_o,
    output logic [dmem_addr_width-4:0]            mem_addr_o,
    output logic [reg_width-1:0]                  mem_wdata_o,
    output logic [7:0]                            mem_byteEn_o,
    input  logic [reg_width-1:0]                  mem_rdata_i
);

    arb_state_t      r_state;
    dmem_cmd_t       r_cmd;
    logic            r_own;
    logic            r_last;
    logic            r_lock;
    logic [3:0]      r_burst;
    logic [NREQ-1:0] r_gnt;
    logic [NREQ-1:0] r_rvalid;
    logic            r_mem_en;
    logic            r_mem_we;

    logic            w_winner;
    dmem_cmd_t       w_cmd;
    logic [3:0]      w_burst_nxt;
    logic            w_unused;

    assign w_unused = ^{addr_i[0][2:0], addr_i[1][2:0]};

    as_rr_pick u_pick (
        .i_req    (req_i),
        .i_last   (r_last),
        .i_lock   (r_lock),
        .i_own    (r_own),
        .o_winner (w_winner)
    );

    always_comb begin
        w_cmd        = '0;
        w_cmd.we     = we_i[w_winner];
        w_cmd.addr   = addr_i[w_winner][dmem_addr_width-1:3];
        w_cmd.wdata  = wdata_i[w_winner];
        w_cmd.byteEn = we_i[w_winner] ? byteEn_i[w_winner] : 8'hFF;
    end

    // Burst length counts repeat grants to one owner; saturates instead of wrapping.
    always_comb begin
        if (r_own != r_last) begin
            w_burst_nxt = 4'd0;
        end else if (r_burst == 4'hF) begin
            w_burst_nxt = r_burst;
        end else begin
            w_burst_nxt = r_burst + 4'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= IDLE;
            r_cmd    <= '0;
            r_own    <= 1'b0;
            r_last   <= 1'b1;
            r_lock   <= 1'b0;
            r_burst  <= 4'd0;
            r_gnt    <= '0;
            r_rvalid <= '0;
            r_mem_en <= 1'b0;
            r_mem_we <= 1'b0;
        end else begin
            r_gnt    <= '0;
            r_rvalid <= '0;
            r_mem_en <= 1'b0;
            r_mem_we <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (r_lock && !req_i[r_own]) begin
                        r_lock  <= 1'b0;
                        r_burst <= 4'd0;
                    end
                    if (|req_i) begin
                        r_own           <= w_winner;
                        r_cmd           <= w_cmd;
                        r_gnt[w_winner] <= 1'b1;
                        r_mem_en        <= 1'b1;
                        r_mem_we        <= w_cmd.we;
                        r_state         <= ACCESS;
                    end
                end
                ACCESS: begin
                    r_last  <= r_own;
                    r_burst <= w_burst_nxt;
                    r_lock  <= lock_i[r_own] && (w_burst_nxt < 4'(MAX_BURST - 1));
                    if (r_cmd.we) begin
                        r_state <= IDLE;
                    end else begin
                        r_rvalid[r_own] <= 1'b1;
                        r_state         <= RESP;
                    end
                end
                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign gnt_o        = r_gnt;
    assign rvalid_o     = r_rvalid;
    assign rdata_o      = (|r_rvalid) ? mem_rdata_i : '0;
    assign mem_en_o     = r_mem_en;
    assign mem_we_o     = r_mem_we;
    assign mem_addr_o   = r_cmd.addr;
    assign mem_wdata_o  = r_cmd.wdata;
    assign mem_byteEn_o = r_cmd.byteEn;

endmodule

// File: tb/tb_as_dmem_arbiter.sv
// Scoreboard bench: stimulus queues commands and pushes expected RAM accesses / read returns.
module tb_as_dmem_arbiter;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [63:0] wdata;
        logic [7:0]  be;
        logic        lock;
        logic        mut;
    } cmd_t;

    typedef struct {
        int          port;
        logic        we;
        logic [12:0] idx;
        logic [63:0] wdata;
        logic [7:0]  be;
    } exp_t;

    typedef struct {
        int          port;
        logic [63:0] data;
    } rd_t;

    logic                  clk;
    logic                  rst_i;
    logic [1:0]            req_i, lock_i, we_i;
    logic [1:0][15:0]      addr_i;
    logic [1:0][63:0]      wdata_i;
    logic [1:0][7:0]       byteEn_i;
    logic [1:0]            gnt_o, rvalid_o;
    logic [63:0]           rdata_o;
    logic                  mem_en_o, mem_we_o;
    logic [12:0]           mem_addr_o;
    logic [63:0]           mem_wdata_o;
    logic [7:0]            mem_byteEn_o;
    logic [63:0]           mem_rdata_i;

    int   errors = 0;
    int   checks = 0;
    cmd_t cq [2][$];
    exp_t eq [$];
    rd_t  rq [$];

    as_dmem_arbiter #(.NREQ(2), .MAX_BURST(4)) dut (
        .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .lock_i(lock_i), .we_i(we_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .byteEn_i(byteEn_i), .gnt_o(gnt_o),
        .rvalid_o(rvalid_o), .rdata_o(rdata_o), .mem_en_o(mem_en_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_byteEn_o(mem_byteEn_o),
        .mem_rdata_i(mem_rdata_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [63:0] ram_word(logic [12:0] idx);
        return 64'hD0D0_0000_0000_0000 | {51'd0, idx};
    endfunction

    // RAM model: read data one cycle after a read strobe.
    initial mem_rdata_i = '0;
    always @(posedge clk) if (mem_en_o && !mem_we_o) mem_rdata_i <= ram_word(mem_addr_o);

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_cmd(int p, logic we, logic [15:0] a, logic [63:0] d, logic [7:0] be,
                            logic lk, logic mut);
        cmd_t c;
        c.we = we; c.addr = a; c.wdata = d; c.be = be; c.lock = lk; c.mut = mut;
        cq[p].push_back(c);
    endtask

    task automatic expect_acc(int p, logic we, logic [12:0] idx, logic [63:0] d, logic [7:0] be,
                              logic rd);
        exp_t e;
        rd_t  r;
        e.port = p; e.we = we; e.idx = idx; e.wdata = d; e.be = be;
        eq.push_back(e);
        if (rd) begin
            r.port = p; r.data = ram_word(idx);
            rq.push_back(r);
        end
    endtask

    task automatic wait_drain(string name);
        for (int i = 0; i < 300; i++) begin
            if (eq.size() == 0 && rq.size() == 0 && cq[0].size() == 0 && cq[1].size() == 0) break;
            @(negedge clk);
        end
        if (eq.size() != 0 || rq.size() != 0 || cq[0].size() != 0 || cq[1].size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: pending acc=%0d rd=%0d", name, eq.size(), rq.size());
            eq.delete(); rq.delete(); cq[0].delete(); cq[1].delete();
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        repeat (2) @(negedge clk);
        rst_i = 1'b0;
    endtask

    // Requester driver: present queue heads, retire on grant, optionally disturb after latch.
    initial begin
        req_i = '0; lock_i = '0; we_i = '0; addr_i = '0; wdata_i = '0; byteEn_i = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int p = 0; p < 2; p++) begin
                if (req_i[p] && cq[p].size() > 0 && cq[p][0].mut) begin
                    addr_i[p] = 16'h0080;
                    req_i[p]  = 1'b0;
                    cq[p][0].mut = 1'b0;
                end
            end
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                if (gnt_o[p] && cq[p].size() > 0) void'(cq[p].pop_front());
                if (cq[p].size() > 0) begin
                    req_i[p]    = 1'b1;
                    we_i[p]     = cq[p][0].we;
                    addr_i[p]   = cq[p][0].addr;
                    wdata_i[p]  = cq[p][0].wdata;
                    byteEn_i[p] = cq[p][0].be;
                    lock_i[p]   = cq[p][0].lock;
                end else begin
                    req_i[p] = 1'b0;
                end
            end
        end
    end

    // Monitor: every RAM access and every read return must match the scoreboard head.
    initial begin
        exp_t       e;
        rd_t        r;
        logic [1:0] g;
        forever begin
            @(negedge clk);
            if (mem_en_o === 1'b1) begin
                checks++;
                if (eq.size() == 0) begin
                    errors++;
                    $display("FAIL access: unexpected idx=%h gnt=%b", mem_addr_o, gnt_o);
                end else begin
                    e = eq.pop_front();
                    g = (e.port == 0) ? 2'b01 : 2'b10;
                    if (gnt_o !== g || mem_we_o !== e.we || mem_addr_o !== e.idx ||
                        mem_byteEn_o !== e.be || mem_wdata_o !== e.wdata) begin
                        errors++;
                        $display("FAIL access: got gnt=%b we=%b idx=%h be=%h wd=%h expected gnt=%b we=%b idx=%h be=%h wd=%h",
                                 gnt_o, mem_we_o, mem_addr_o, mem_byteEn_o, mem_wdata_o,
                                 g, e.we, e.idx, e.be, e.wdata);
                    end
                end
            end else if (gnt_o !== 2'b00 && rst_i === 1'b0) begin
                checks++;
                errors++;
                $display("FAIL grant: got %b without mem_en", gnt_o);
            end
            if (rvalid_o !== 2'b00 && rvalid_o !== 2'bxx) begin
                checks++;
                if (rq.size() == 0) begin
                    errors++;
                    $display("FAIL rvalid: unexpected %b", rvalid_o);
                end else begin
                    r = rq.pop_front();
                    g = (r.port == 0) ? 2'b01 : 2'b10;
                    if (rvalid_o !== g || rdata_o !== r.data) begin
                        errors++;
                        $display("FAIL rvalid: got %b/%h expected %b/%h", rvalid_o, rdata_o, g, r.data);
                    end
                end
            end else if (rst_i === 1'b0) begin
                chk("rdata_idle", rdata_o, 64'd0);
            end
        end
    end

    initial begin
        bit seen;
        rst_i = 1'b1;
        repeat (3) @(negedge clk);
        rst_i = 1'b0;
        chk("rst_gnt", gnt_o, 0);
        chk("rst_rvalid", rvalid_o, 0);
        chk("rst_mem_en", mem_en_o, 0);
        chk("rst_mem_we", mem_we_o, 0);
        chk("rst_mem_addr", mem_addr_o, 0);
        chk("rst_mem_wdata", mem_wdata_o, 0);
        chk("rst_mem_be", mem_byteEn_o, 0);
        chk("rst_rdata", rdata_o, 0);

        // Single load from port 0 with latency checks.
        push_cmd(0, 1'b0, 16'h0018, 64'd0, 8'h00, 1'b0, 1'b0);
        expect_acc(0, 1'b0, 13'd3, 64'd0, 8'hFF, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk);
            seen = req_i[0];
        end
        chk("load_req_seen", {63'd0, seen}, 64'd1);
        @(negedge clk);
        chk("load_n1_mem_en", mem_en_o, 1);
        chk("load_n1_gnt", gnt_o, 2'b01);
        @(negedge clk);
        chk("load_n2_rvalid", rvalid_o, 2'b01);
        chk("load_n2_rdata", rdata_o, ram_word(13'd3));
        wait_drain("load");

        // Tie after reset: port 0 first, load-style FF only for loads.
        do_reset();
        push_cmd(0, 1'b1, 16'h0005, 64'h0000_AB00_0000_0000, 8'h20, 1'b0, 1'b0);
        push_cmd(1, 1'b1, 16'h0008, 64'h1122_3344_5566_7788, 8'hFF, 1'b0, 1'b0);
        expect_acc(0, 1'b1, 13'd0, 64'h0000_AB00_0000_0000, 8'h20, 1'b0);
        expect_acc(1, 1'b1, 13'd1, 64'h1122_3344_5566_7788, 8'hFF, 1'b0);
        wait_drain("tie");

        // Burst lock: four port-1 grants, then alternation resumes.
        push_cmd(0, 1'b1, 16'h0300, 64'd3, 8'hFF, 1'b0, 1'b0);
        expect_acc(0, 1'b1, 13'h060, 64'd3, 8'hFF, 1'b0);
        wait_drain("burst_pre");
        for (int k = 0; k < 5; k++)
            push_cmd(1, 1'b1, 16'h0100 + 16'(8 * k), 64'(k + 16), 8'hFF, 1'b1, 1'b0);
        push_cmd(0, 1'b1, 16'h0200, 64'hA0, 8'hFF, 1'b0, 1'b0);
        push_cmd(0, 1'b1, 16'h0208, 64'hA1, 8'hFF, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++)
            expect_acc(1, 1'b1, 13'h020 + 13'(k), 64'(k + 16), 8'hFF, 1'b0);
        expect_acc(0, 1'b1, 13'h040, 64'hA0, 8'hFF, 1'b0);
        expect_acc(1, 1'b1, 13'h024, 64'd20, 8'hFF, 1'b0);
        expect_acc(0, 1'b1, 13'h041, 64'hA1, 8'hFF, 1'b0);
        wait_drain("burst");

        // Lock owner drops request: port 1 proceeds, then a tie goes to port 0.
        push_cmd(0, 1'b1, 16'h0400, 64'd4, 8'h0F, 1'b1, 1'b0);
        expect_acc(0, 1'b1, 13'h080, 64'd4, 8'h0F, 1'b0);
        wait_drain("lock_own");
        push_cmd(1, 1'b0, 16'h0408, 64'd0, 8'h00, 1'b0, 1'b0);
        expect_acc(1, 1'b0, 13'h081, 64'd0, 8'hFF, 1'b1);
        wait_drain("lock_drop");
        push_cmd(0, 1'b1, 16'h0410, 64'd5, 8'hFF, 1'b0, 1'b0);
        push_cmd(1, 1'b1, 16'h0418, 64'd6, 8'hFF, 1'b0, 1'b0);
        expect_acc(0, 1'b1, 13'h082, 64'd5, 8'hFF, 1'b0);
        expect_acc(1, 1'b1, 13'h083, 64'd6, 8'hFF, 1'b0);
        wait_drain("lock_tie");

        // Reset during the access cycle of a load: the read never returns.
        push_cmd(0, 1'b0, 16'h0030, 64'd0, 8'h00, 1'b0, 1'b0);
        expect_acc(0, 1'b0, 13'd6, 64'd0, 8'hFF, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = mem_en_o;
        end
        chk("rst_mid_access_seen", {63'd0, seen}, 64'd1);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        chk("rst_mid_mem_en", mem_en_o, 0);
        chk("rst_mid_rvalid", rvalid_o, 0);
        @(negedge clk);
        chk("rst_mid_rvalid2", rvalid_o, 0);
        push_cmd(0, 1'b1, 16'h0048, 64'd7, 8'hFF, 1'b0, 1'b0);
        push_cmd(1, 1'b1, 16'h0050, 64'd8, 8'hFF, 1'b0, 1'b0);
        expect_acc(0, 1'b1, 13'd9, 64'd7, 8'hFF, 1'b0);
        expect_acc(1, 1'b1, 13'd10, 64'd8, 8'hFF, 1'b0);
        wait_drain("rst_mid_tie");

        // Request and address disturbed after latch: RAM still sees 0x40.
        @(negedge clk);
        push_cmd(0, 1'b0, 16'h0040, 64'd0, 8'h00, 1'b0, 1'b1);
        expect_acc(0, 1'b0, 13'd8, 64'd0, 8'hFF, 1'b1);
        wait_drain("stable");
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/as_dmem_arbiter.md
# as_dmem_arbiter

Shares the single byte-enabled data-memory port between two requesters: the core load/store path (port 0) and the program-loader/debug path (port 1). It sits between the requesters' store-alignment front end and the synchronous RAM. It arbitrates round-robin with an optional bounded burst lock, registers the winning request, drives one RAM access, and returns read data with a valid pulse.

## Interface
Parameters:
- `NREQ`, 2: number of requesters; fixed at 2 in this revision.
- `MAX_BURST`, 4: maximum consecutive grants one locked requester may take while the other is waiting; range 1..15.

Ports (per-requester signals are arrays indexed [NREQ-1:0]):
- `clk_i`  in  1  system clock; all state changes on the rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `req_i`  in  NREQ  access request; held until `gnt_o`.
- `lock_i`  in  NREQ  owner requests to keep the port for its next access.
- `we_i`  in  NREQ  1 = store, 0 = load.
- `addr_i`  in  NREQ x dmem_addr_width  byte address.
- `wdata_i`  in  NREQ x reg_width  write data, already lane-aligned.
- `byteEn_i`  in  NREQ x 8  byte enables; ignored for loads.
- `gnt_o`  out  NREQ  one-cycle pulse: request accepted.
- `rvalid_o`  out  NREQ  one-cycle pulse: `rdata_o` valid for this requester.
- `rdata_o`  out  reg_width  read data, shared by both requesters.
- `mem_en_o`  out  1  RAM access strobe.
- `mem_we_o`  out  1  RAM write enable.
- `mem_addr_o`  out  dmem_addr_width-3  doubleword index, taken from addr[awidth-1:3].
- `mem_wdata_o`  out  reg_width  RAM write data.
- `mem_byteEn_o`  out  8  RAM byte enables.
- `mem_rdata_i`  in  reg_width  RAM read data; valid one cycle after `mem_en_o` with `mem_we_o`=0.

## Operation
FSM states: IDLE, ACCESS, RESP.
- **IDLE**
  - No request: stay in IDLE.
  - Request present: pick a winner, latch its `we`/`addr`/`wdata`/`byteEn` and its index `own_q`, then go to ACCESS.
- **Winner selection** (evaluated in order):
  - If `lock_q` is set and `req_i[own_q]` is high, `own_q` wins.
  - Otherwise, if only one request is high, that requester wins.
  - Otherwise (both high), the requester that is not `last_q` wins.
- **ACCESS**
  - Drive `mem_en_o`=1 with the registered command.
  - Pulse `gnt_o[own_q]`.
  - Set `last_q`=`own_q`.
  - Write: go to IDLE. Read: go to RESP.
- **RESP**
  - `rdata_o`=`mem_rdata_i` and `rvalid_o[own_q]`=1; go to IDLE.
  - `rdata_o` is 0 in every other state.
- **Burst lock** (evaluated on the ACCESS→next-state edge):
  - `lock_q` = `lock_i[own_q]` && (`burst_q` < `MAX_BURST`-1).
  - `burst_q` increments when the same owner is granted consecutively; it clears to 0 when ownership changes.
  - If `lock_q` is set but the owner has dropped `req_i`, the lock clears and normal round-robin applies.
  - `burst_q` saturates, so it never wraps.
- **Data path**: no data transformation. Byte enables pass through unchanged for stores and are forced to 8'hFF for loads.
- **Reset**, from any state:
  - State goes to IDLE.
  - `gnt_o`, `rvalid_o`, `mem_en_o`, `mem_we_o` = 0.
  - `mem_addr_o`, `mem_wdata_o`, `mem_byteEn_o`, `rdata_o` = 0.
  - `last_q`=1, so port 0 wins the first tie.
  - `lock_q`=0, `burst_q`=0.
  - An in-flight read yields no `rvalid_o`.

## Timing
- Request sampled in IDLE at edge N → `mem_en_o` and `gnt_o` high during cycle N+1.
- Read: `rvalid_o` high during cycle N+2; next arbitration at edge N+3 at the earliest.
- Throughput: one write per 2 cycles; one read per 3 cycles.
- All outputs are registered or decoded from state only. There is no combinational path from `req_i` to any output.
- Requesters must hold `req_i` and command stable until `gnt_o`. Changes made earlier are ignored once latched.
- `req_i` high in the same cycle as `gnt_o` is treated as a new request at the next IDLE.

## Structure
- `as_pack` supplies `reg_width` and `dmem_addr_width`.
- Add to `as_pack`:
  - `arb_state_t` enum (IDLE, ACCESS, RESP).
  - `dmem_cmd_t` packed struct: we, addr, wdata, byteEn.
- Natural sub-module: `as_rr_pick`, a combinational 2-way round-robin selector with lock override (inputs req, last, lock, own; output winner index).
- The FSM, command register and burst counter stay in `as_dmem_arbiter`.

## Test plan
1. **Reset**: after reset, all outputs are 0. Port 0 alone, load addr 0x18 → `mem_addr_o`=3 at N+1, `gnt_o`=01 at N+1, `rvalid_o`=01 at N+2 with `rdata_o`=`mem_rdata_i`.
2. **Tie**: both ports request (port 0 sb addr 0x5 byteEn 8'h20, port 1 sd addr 0x8) → grants in order port 0, then port 1. `mem_byteEn_o` is 8'h20, then 8'hFF.
3. **Burst lock**: port 1 holds `lock_i`, MAX_BURST=4, port 0 requests continuously → exactly 4 port-1 grants, then port 0 is granted.
4. **Lock without request**: port 0 locked but drops `req_i`, port 1 requesting → port 1 granted at the next IDLE; `burst_q` clears.
5. **Reset mid-read**: `rst_i` asserted in ACCESS of a load → no `rvalid_o`; the FSM is in IDLE in the following cycle; then port 0 wins a tie.
6. **Stability**: `req_i`/`addr_i` changed after latch, before `gnt_o` → RAM sees the originally latched address 0x40 (`mem_addr_o`=8).
